// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU. One requester is granted
// per cycle (fixed priority with aging, or round-robin); results return one cycle later.
module alu_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int RR_MODE    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_f,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_f,
  input  logic [4:0]  req1_shamt,
  output logic        resp0_valid,
  output logic [31:0] resp0_y,
  output logic        resp0_zero,
  output logic        resp0_err,
  output logic        resp1_valid,
  output logic [31:0] resp1_y,
  output logic        resp1_zero,
  output logic        resp1_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_f,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_y,
  input  logic        alu_zero
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b1010,
    OP_NOR = 4'b0011,
    OP_XOR = 4'b0111,
    OP_SLT = 4'b1011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101
  } alu_op_e;

  typedef struct packed {
    logic [31:0] y;
    logic        zero;
    logic        err;
  } resp_t;

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  function automatic logic op_legal(input logic [3:0] f);
    case (f)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR,
      OP_XOR, OP_SLT, OP_SLL, OP_SRL: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  endfunction

  // Illegal ops never reach the ALU, so their response is synthesised here.
  function automatic resp_t next_resp(input logic granted, input logic legal,
                                      input resp_t cur, input logic [31:0] y,
                                      input logic zero);
    next_resp = cur;
    if (granted) begin
      if (legal) begin
        next_resp.y    = y;
        next_resp.zero = zero;
        next_resp.err  = 1'b0;
      end else begin
        next_resp.y    = 32'd0;
        next_resp.zero = 1'b1;
        next_resp.err  = 1'b1;
      end
    end
  endfunction

  logic       legal0, legal1;
  logic       grant0, grant1;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       last_grant_q, last_grant_d;
  logic       resp0_valid_q, resp1_valid_q;
  resp_t      resp0_q, resp0_d, resp1_q, resp1_d;

  assign legal0 = op_legal(req0_f);
  assign legal1 = op_legal(req1_f);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        if (RR_MODE != 0) begin
          grant0 = last_grant_q;
          grant1 = !last_grant_q;
        end else if (starve_cnt_q == STARVE_LIMIT) begin
          grant1 = 1'b1;
        end else begin
          grant0 = 1'b1;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req1_valid || grant1) begin
      starve_cnt_d = 4'd0;
    end else if (grant0 && (starve_cnt_q < STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    last_grant_d = last_grant_q;
    if (grant0) begin
      last_grant_d = 1'b0;
    end else if (grant1) begin
      last_grant_d = 1'b1;
    end

    resp0_d = next_resp(grant0, legal0, resp0_q, alu_y, alu_zero);
    resp1_d = next_resp(grant1, legal1, resp1_q, alu_y, alu_zero);
  end

  always_comb begin
    alu_a     = 32'd0;
    alu_b     = 32'd0;
    alu_f     = 4'b0000;
    alu_shamt = 5'd0;
    if (grant0 && legal0) begin
      alu_a     = req0_a;
      alu_b     = req0_b;
      alu_f     = req0_f;
      alu_shamt = req0_shamt;
    end else if (grant1 && legal1) begin
      alu_a     = req1_a;
      alu_b     = req1_b;
      alu_f     = req1_f;
      alu_shamt = req1_shamt;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      starve_cnt_q  <= 4'd0;
      last_grant_q  <= 1'b1;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_q       <= '0;
      resp1_q       <= '0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      last_grant_q  <= last_grant_d;
      resp0_valid_q <= grant0;
      resp1_valid_q <= grant1;
      resp0_q       <= resp0_d;
      resp1_q       <= resp1_d;
    end
  end

  // Gating with reset drops a pulse whose cycle coincides with a reset assertion.
  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = resp0_valid_q && !reset;
  assign resp1_valid = resp1_valid_q && !reset;
  assign resp0_y     = resp0_q.y;
  assign resp0_zero  = resp0_q.zero;
  assign resp0_err   = resp0_q.err;
  assign resp1_y     = resp1_q.y;
  assign resp1_zero  = resp1_q.zero;
  assign resp1_err   = resp1_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance 0 runs fixed priority with aging, instance 1 runs
// round-robin; both share one clock/reset and see a behavioural ALU and reference model.
module tb_alu_arbiter;

  localparam int N          = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [N][2];
  logic        req_ready [N][2];
  logic [31:0] req_a     [N][2];
  logic [31:0] req_b     [N][2];
  logic [3:0]  req_f     [N][2];
  logic [4:0]  req_sh    [N][2];
  logic        resp_valid[N][2];
  logic [31:0] resp_y    [N][2];
  logic        resp_zero [N][2];
  logic        resp_err  [N][2];
  logic [31:0] alu_a [N];
  logic [31:0] alu_b [N];
  logic [3:0]  alu_f [N];
  logic [4:0]  alu_sh[N];
  logic [31:0] alu_y [N];
  logic        alu_zero[N];

  logic [3:0] legal_codes [9];

  int          m_starve[N];
  int          m_last  [N];
  int          m_grant [N];
  logic        m_rv[N][2];
  logic [31:0] m_y [N][2];
  logic        m_z [N][2];
  logic        m_e [N][2];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] f, input logic [4:0] sh);
    case (f)
      4'b0000: alu_fn = a & b;
      4'b0001: alu_fn = a | b;
      4'b0010: alu_fn = a + b;
      4'b1010: alu_fn = a - b;
      4'b0011: alu_fn = ~(a | b);
      4'b0111: alu_fn = a ^ b;
      4'b1011: alu_fn = {31'd0, ($signed(a) < $signed(b))};
      4'b0100: alu_fn = b << sh;
      4'b0101: alu_fn = b >> sh;
      default: alu_fn = 32'd0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] f);
    is_legal = 1'b0;
    foreach (legal_codes[k]) if (legal_codes[k] == f) is_legal = 1'b1;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : gen_dut
    alu_arbiter #(.STARVE_MAX(STARVE_MAX), .RR_MODE(gi)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req_valid[gi][0]), .req0_ready(req_ready[gi][0]),
      .req0_a(req_a[gi][0]), .req0_b(req_b[gi][0]), .req0_f(req_f[gi][0]), .req0_shamt(req_sh[gi][0]),
      .req1_valid(req_valid[gi][1]), .req1_ready(req_ready[gi][1]),
      .req1_a(req_a[gi][1]), .req1_b(req_b[gi][1]), .req1_f(req_f[gi][1]), .req1_shamt(req_sh[gi][1]),
      .resp0_valid(resp_valid[gi][0]), .resp0_y(resp_y[gi][0]),
      .resp0_zero(resp_zero[gi][0]), .resp0_err(resp_err[gi][0]),
      .resp1_valid(resp_valid[gi][1]), .resp1_y(resp_y[gi][1]),
      .resp1_zero(resp_zero[gi][1]), .resp1_err(resp_err[gi][1]),
      .alu_a(alu_a[gi]), .alu_b(alu_b[gi]), .alu_f(alu_f[gi]), .alu_shamt(alu_sh[gi]),
      .alu_y(alu_y[gi]), .alu_zero(alu_zero[gi])
    );
    assign alu_y[gi]    = alu_fn(alu_a[gi], alu_b[gi], alu_f[gi], alu_sh[gi]);
    assign alu_zero[gi] = (alu_y[gi] == 32'd0);
  end

  // Winner for instance i this cycle, -1 for none; instance 1 is the round-robin one.
  function automatic int model_grant(input int i);
    model_grant = -1;
    if (!reset) begin
      if (req_valid[i][0] && req_valid[i][1]) begin
        if (i == 1) model_grant = (m_last[i] == 0) ? 1 : 0;
        else        model_grant = (m_starve[i] == STARVE_MAX) ? 1 : 0;
      end else if (req_valid[i][0]) begin
        model_grant = 0;
      end else if (req_valid[i][1]) begin
        model_grant = 1;
      end
    end
  endfunction

  // Advance one clock edge and update the reference model; optionally raise reset
  // right at the edge so the following cycle starts in reset.
  task automatic tick(input bit rst_after = 1'b0);
    int   g[N];
    logic rst_pre;
    rst_pre = reset;
    for (int i = 0; i < N; i++) g[i] = model_grant(i);
    @(posedge clk);
    if (rst_after) reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_grant[i] = g[i];
      if (rst_pre) begin
        m_starve[i] = 0;
        m_last[i]   = 1;
        for (int p = 0; p < 2; p++) begin
          m_rv[i][p] = 1'b0; m_y[i][p] = 32'd0; m_z[i][p] = 1'b0; m_e[i][p] = 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          m_rv[i][p] = (g[i] == p);
          if (g[i] == p) begin
            if (is_legal(req_f[i][p])) begin
              m_y[i][p] = alu_fn(req_a[i][p], req_b[i][p], req_f[i][p], req_sh[i][p]);
              m_z[i][p] = (m_y[i][p] == 32'd0);
              m_e[i][p] = 1'b0;
            end else begin
              m_y[i][p] = 32'd0; m_z[i][p] = 1'b1; m_e[i][p] = 1'b1;
            end
          end
        end
        if (g[i] == 1 || !req_valid[i][1]) m_starve[i] = 0;
        else if (m_starve[i] < STARVE_MAX)  m_starve[i]++;
        if (g[i] >= 0) m_last[i] = g[i];
      end
    end
    #1;
  endtask

  task automatic set_idle();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 2; p++) begin
        req_valid[i][p] = 1'b0; req_a[i][p] = '0; req_b[i][p] = '0;
        req_f[i][p] = '0; req_sh[i][p] = '0;
      end
  endtask

  task automatic drive(input int i, input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] f, input logic [4:0] sh);
    req_valid[i][p] = 1'b1; req_a[i][p] = a; req_b[i][p] = b; req_f[i][p] = f; req_sh[i][p] = sh;
  endtask

  // Leaves the bench at a falling edge with reset low and all requesters idle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_idle();
    tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      drive(i, 0, 32'd9, 32'd4, 4'b0010, 5'd0);
      drive(i, 1, 32'd1, 32'd2, 4'b0001, 5'd0);
    end
    #1;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 2; p++) begin
        n_cmp += 2;
        if (req_ready[i][p] !== 1'b0) begin
          n_bad++; $display("FAIL reset_ready[%0d][%0d]: got %b want 0", i, p, req_ready[i][p]);
        end
        if (resp_valid[i][p] !== 1'b0) begin
          n_bad++; $display("FAIL reset_resp_valid[%0d][%0d]: got %b want 0", i, p, resp_valid[i][p]);
        end
      end
      n_cmp++;
      if (alu_f[i] !== 4'd0 || alu_a[i] !== 32'd0) begin
        n_bad++; $display("FAIL reset_alu[%0d]: got f=%h a=%h want 0", i, alu_f[i], alu_a[i]);
      end
    end
    tick();
    tick();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 2; p++) begin
        n_cmp++;
        if ({resp_y[i][p], resp_zero[i][p], resp_err[i][p]} !== 34'd0) begin
          n_bad++;
          $display("FAIL reset_resp_regs[%0d][%0d]: got y=%h z=%b e=%b want 0", i, p,
                   resp_y[i][p], resp_zero[i][p], resp_err[i][p]);
        end
      end
    n_cmp++;
    if (gen_dut[0].u_dut.starve_cnt_q !== 4'd0) begin
      n_bad++; $display("FAIL reset_starve: got %0d want 0", gen_dut[0].u_dut.starve_cnt_q);
    end
    @(negedge clk);
    reset = 1'b0;
    set_idle();
  endtask

  task automatic test_port0_sub();
    @(negedge clk);
    set_idle();
    drive(0, 0, 32'd7, 32'd5, 4'b1010, 5'd0);
    #1;
    n_cmp += 2;
    if (req_ready[0][0] !== 1'b1 || req_ready[0][1] !== 1'b0) begin
      n_bad++; $display("FAIL p0_sub_ready: got %b%b want 10", req_ready[0][0], req_ready[0][1]);
    end
    if (alu_a[0] !== 32'd7 || alu_b[0] !== 32'd5 || alu_f[0] !== 4'b1010) begin
      n_bad++; $display("FAIL p0_sub_alu: got a=%0d b=%0d f=%b want 7 5 1010", alu_a[0], alu_b[0], alu_f[0]);
    end
    tick();
    n_cmp++;
    if (resp_valid[0][0] !== 1'b1 || resp_y[0][0] !== 32'd2 || resp_zero[0][0] !== 1'b0) begin
      n_bad++;
      $display("FAIL p0_sub_resp: got v=%b y=%0d z=%b want 1 2 0", resp_valid[0][0], resp_y[0][0], resp_zero[0][0]);
    end
    @(negedge clk);
    req_valid[0][0] = 1'b0;
    tick();
    n_cmp++;
    if (resp_valid[0][0] !== 1'b0 || resp_y[0][0] !== 32'd2) begin
      n_bad++; $display("FAIL p0_hold: got v=%b y=%0d want 0 2", resp_valid[0][0], resp_y[0][0]);
    end
  endtask

  task automatic test_port1_zero();
    @(negedge clk);
    set_idle();
    drive(0, 1, 32'd3, 32'd3, 4'b1010, 5'd0);
    tick();
    n_cmp++;
    if (resp_valid[0][1] !== 1'b1 || resp_y[0][1] !== 32'd0 || resp_zero[0][1] !== 1'b1
        || resp_err[0][1] !== 1'b0) begin
      n_bad++;
      $display("FAIL p1_zero_resp: got v=%b y=%0d z=%b e=%b want 1 0 1 0", resp_valid[0][1],
               resp_y[0][1], resp_zero[0][1], resp_err[0][1]);
    end
    @(negedge clk);
    set_idle();
  endtask

  // Runs a both-valid contention sequence on instance i and compares winners.
  task automatic run_contention(input int i, input int len, input int exp_seq[10], input string tag);
    do_reset();
    drive(i, 0, $urandom, $urandom, 4'b0010, 5'd0);
    drive(i, 1, $urandom, $urandom, 4'b0111, 5'd0);
    for (int k = 0; k < len; k++) begin
      int got;
      #1;
      got = req_ready[i][0] ? 0 : (req_ready[i][1] ? 1 : -1);
      n_cmp++;
      if (got !== exp_seq[k] || (req_ready[i][0] && req_ready[i][1])) begin
        n_bad++; $display("FAIL %s_grant[%0d]: got %0d want %0d", tag, k, got, exp_seq[k]);
      end
      tick();
      n_cmp++;
      if (resp_valid[i][exp_seq[k]] !== 1'b1 || resp_y[i][exp_seq[k]] !== m_y[i][exp_seq[k]]) begin
        n_bad++;
        $display("FAIL %s_resp[%0d]: got v=%b y=%h want 1 %h", tag, k, resp_valid[i][exp_seq[k]],
                 resp_y[i][exp_seq[k]], m_y[i][exp_seq[k]]);
      end
      @(negedge clk);
    end
    set_idle();
  endtask

  task automatic test_starve_seq();
    int exp_seq[10];
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    run_contention(0, 10, exp_seq, "starve");
  endtask

  task automatic test_rr_seq();
    int exp_seq[10];
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    run_contention(1, 4, exp_seq, "rr");
  endtask

  task automatic test_illegal();
    @(negedge clk);
    set_idle();
    drive(0, 0, 32'hdead_beef, 32'h1234, 4'b1111, 5'd3);
    #1;
    n_cmp += 2;
    if (req_ready[0][0] !== 1'b1) begin
      n_bad++; $display("FAIL illegal_ready: got %b want 1", req_ready[0][0]);
    end
    if (alu_f[0] !== 4'd0 || alu_a[0] !== 32'd0 || alu_b[0] !== 32'd0 || alu_sh[0] !== 5'd0) begin
      n_bad++;
      $display("FAIL illegal_alu: got f=%b a=%h b=%h sh=%0d want 0", alu_f[0], alu_a[0], alu_b[0], alu_sh[0]);
    end
    tick();
    n_cmp++;
    if (resp_valid[0][0] !== 1'b1 || resp_err[0][0] !== 1'b1 || resp_y[0][0] !== 32'd0
        || resp_zero[0][0] !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_resp: got v=%b e=%b y=%h z=%b want 1 1 0 1", resp_valid[0][0],
               resp_err[0][0], resp_y[0][0], resp_zero[0][0]);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_reset_suppress();
    @(negedge clk);
    set_idle();
    drive(0, 1, $urandom, 32'd1, 4'b0100, 5'd4);
    #1;
    n_cmp++;
    if (req_ready[0][1] !== 1'b1 || alu_f[0] !== 4'b0100 || alu_sh[0] !== 5'd4) begin
      n_bad++; $display("FAIL sup_grant: got r=%b f=%b sh=%0d want 1 0100 4", req_ready[0][1], alu_f[0], alu_sh[0]);
    end
    tick(1'b1);
    n_cmp++;
    if (resp_valid[0][1] !== 1'b0) begin
      n_bad++; $display("FAIL sup_pulse_edge: got %b want 0", resp_valid[0][1]);
    end
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++;
    if (resp_valid[0][1] !== 1'b0) begin
      n_bad++; $display("FAIL sup_pulse_mid: got %b want 0", resp_valid[0][1]);
    end
    tick();
    n_cmp += 2;
    if (gen_dut[0].u_dut.starve_cnt_q !== 4'd0) begin
      n_bad++; $display("FAIL sup_starve: got %0d want 0", gen_dut[0].u_dut.starve_cnt_q);
    end
    if (resp_valid[0][1] !== 1'b0 || resp_y[0][1] !== 32'd0) begin
      n_bad++; $display("FAIL sup_resp: got v=%b y=%h want 0 0", resp_valid[0][1], resp_y[0][1]);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_cmp++;
    if (resp_valid[0][1] !== 1'b0) begin
      n_bad++; $display("FAIL sup_after: got %b want 0", resp_valid[0][1]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_idle();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, $urandom, $urandom, legal_codes[$urandom_range(0, 8)], 5'($urandom));
      tick();
      n_cmp++;
      if (resp_valid[0][0] !== 1'b1 || resp_y[0][0] !== m_y[0][0]) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got v=%b y=%h want 1 %h", k, resp_valid[0][0], resp_y[0][0], m_y[0][0]);
      end
      @(negedge clk);
    end
    set_idle();
    tick();
    n_cmp++;
    if (resp_valid[0][0] !== 1'b0) begin
      n_bad++; $display("FAIL b2b_end: got %b want 0", resp_valid[0][0]);
    end
  endtask

  task automatic test_random();
    @(negedge clk);
    set_idle();
    for (int i = 0; i < N; i++) m_grant[i] = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++)
        for (int p = 0; p < 2; p++)
          if (!(req_valid[i][p] && m_grant[i] != p)) begin
            req_valid[i][p] = ($urandom_range(0, 9) < 7);
            req_f[i][p]  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 8)];
            req_a[i][p]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            req_b[i][p]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            req_sh[i][p] = 5'($urandom);
          end
      #1;
      for (int i = 0; i < N; i++) begin
        int          g;
        logic [72:0] exp_alu;
        g = model_grant(i);
        exp_alu = '0;
        if (g >= 0 && is_legal(req_f[i][g]))
          exp_alu = {req_a[i][g], req_b[i][g], req_f[i][g], req_sh[i][g]};
        n_cmp += 2;
        if (req_ready[i][0] !== (g == 0) || req_ready[i][1] !== (g == 1)) begin
          n_bad++;
          $display("FAIL rnd_ready[%0d] cyc %0d: got %b%b want grant %0d", i, cyc,
                   req_ready[i][0], req_ready[i][1], g);
        end
        if ({alu_a[i], alu_b[i], alu_f[i], alu_sh[i]} !== exp_alu) begin
          n_bad++;
          $display("FAIL rnd_alu[%0d] cyc %0d: got %h want %h", i, cyc,
                   {alu_a[i], alu_b[i], alu_f[i], alu_sh[i]}, exp_alu);
        end
      end
      tick();
      for (int i = 0; i < N; i++)
        for (int p = 0; p < 2; p++) begin
          n_cmp++;
          if (resp_valid[i][p] !== (m_rv[i][p] && !reset) || resp_y[i][p] !== m_y[i][p]
              || resp_zero[i][p] !== m_z[i][p] || resp_err[i][p] !== m_e[i][p]) begin
            n_bad++;
            $display("FAIL rnd_resp[%0d][%0d] cyc %0d: got v=%b y=%h z=%b e=%b want %b %h %b %b",
                     i, p, cyc, resp_valid[i][p], resp_y[i][p], resp_zero[i][p], resp_err[i][p],
                     m_rv[i][p] && !reset, m_y[i][p], m_z[i][p], m_e[i][p]);
          end
        end
      n_cmp++;
      if (gen_dut[0].u_dut.starve_cnt_q !== 4'(m_starve[0])) begin
        n_bad++;
        $display("FAIL rnd_starve cyc %0d: got %0d want %0d", cyc, gen_dut[0].u_dut.starve_cnt_q, m_starve[0]);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    set_idle();
  endtask

  initial begin
    legal_codes = '{4'b0000, 4'b0001, 4'b0010, 4'b1010, 4'b0011,
                    4'b0111, 4'b1011, 4'b0100, 4'b0101};
    for (int i = 0; i < N; i++) begin
      m_starve[i] = 0; m_last[i] = 1; m_grant[i] = -1;
      for (int p = 0; p < 2; p++) begin
        m_rv[i][p] = 1'b0; m_y[i][p] = '0; m_z[i][p] = 1'b0; m_e[i][p] = 1'b0;
      end
    end
    reset = 1'b1;
    set_idle();
    test_reset();
    test_port0_sub();
    test_port1_zero();
    test_starve_seq();
    test_rr_seq();
    test_illegal();
    test_reset_suppress();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
